lsq_mem_ctrl: RTL
=================

Name: lsq_mem_ctrl

Overview:
- Memory-side sequencer between the load/store queue and the byte-wide single-port main memory.
- Accepts one 32-bit load/store request at a time and performs it as consecutive single-byte memory accesses, little-endian.
- For loads, assembles the bytes and sign/zero-extends the result; returns a tagged response to the LSQ/ROB.

Parameters:
- ADDR_WIDTH, 20, memory address width; req_addr bits above this are ignored.
- TAG_WIDTH, 6, ROB tag width, matching rob_num.
- MEM_RD_LAT, 1, cycles from mem_re to valid mem_rdata; legal range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; active-low, asynchronous.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_wr  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low bytes used.
- req_tag  in  TAG_WIDTH  ROB tag.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  32  load result; 0 for stores.
- resp_tag  out  TAG_WIDTH  echoed tag.
- resp_wr  out  1  echoed req_wr.
- resp_err  out  1  request faulted; no memory access was made.
- mem_cs  out  1  memory chip select.
- mem_re  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - req_ready=0 while reset is held, and 1 in IDLE afterwards.
  - resp_valid, resp_err, resp_wr, resp_data, resp_tag, and all mem_* outputs are 0.
  - Any in-flight operation is dropped, including a partially written store.
- States:
  - IDLE: req_ready=1. A request is accepted on req_valid. All request fields are registered, byte counter cnt=0, nbytes=1/2/4.
    - Illegal size, or a fault (see Optional Feature): go to RESP with resp_err=1.
    - Otherwise go to ACCESS.
  - ACCESS: mem_cs=1 and mem_addr=(addr+cnt) mod 2^ADDR_WIDTH.
    - Store: mem_wr=1, mem_wdata=wdata[8*cnt+:8]. Then cnt++. When cnt==nbytes-1 before the increment, go to RESP; otherwise stay in ACCESS.
    - Load: mem_re=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold mem_cs=1 with mem_re=0 and wait MEM_RD_LAT cycles.
    - On the last cycle, capture mem_rdata into byte cnt of the assembly register and do cnt++.
    - If all bytes are done, go to RESP; otherwise go to ACCESS.
  - RESP: resp_valid=1 and all resp_* outputs are stable. On resp_ready, go to IDLE. req_ready=0.
- Latency for an accept edge at cycle T, MEM_RD_LAT=1:
  - Word store: mem_wr in T+1..T+4, resp_valid from T+5.
  - Word load: mem_re at T+1, T+3, T+5, T+7; resp_valid from T+9.
  - Byte load: resp_valid from T+3.
  - Error: resp_valid from T+1.
- Load extension: the result is extended from bit 8*nbytes-1. Words are unaffected.
- Throughput: no overlap between requests. req_ready is 0 in ACCESS, WAIT and RESP.
  - A request held while the block is busy is accepted in the first IDLE cycle.
  - resp_ready asserted outside RESP is ignored.
- Address arithmetic is ADDR_WIDTH-bit; the top address wraps to 0.

Optional Feature:
- Macro LSQ_MEM_CTRL_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]!=0, or a word access with addr[1:0]!=0, produces resp_err=1 with no mem strobes.
- Undefined: misaligned accesses proceed byte-wise at the actual addresses, with wrap-around. Only size 11 faults.

Decomposition:
- Shared package lsq_mem_pkg holds:
  - State encoding IDLE/ACCESS/WAIT/RESP.
  - Size codes SZ_B/SZ_H/SZ_W.
  - The nbytes lookup.
  - The request struct {wr, size, unsigned, addr, wdata, tag}.
- One natural sub-module: load_extend, combinational byte assembly plus sign/zero extension.

Test Plan:
- Word store addr=0x100, wdata=0xDEADBEEF: bytes written are 100:EF, 101:BE, 102:AD, 103:DE. Resp at T+5 with err=0 and data=0.
- Byte load at 0x103 (mem=0xDE): signed gives 0xFFFFFFDE; unsigned gives 0x000000DE.
- Half load at 0x102: result 0xFFFFDEAD, with resp_valid held 3 cycles under resp_ready=0 and stable tag=0x2A.
- Word load at 0x101:
  - Macro on: err=1 at T+1 with zero mem_re.
  - Macro off: bytes read from 101..104.
  - Separately, a word store at 0xFFFFE (macro off) wraps: bytes go to 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- req_size=11: resp_err=1 with no mem access.
- rst pulled low during byte 2 of a word store: all outputs are 0 immediately. After release, req_ready=1 and a new byte load completes correctly.

Source files
------------

// File: rtl/lsq_mem_pkg.sv
// rtl/lsq_mem_pkg.sv - shared FSM states, size codes, request struct and byte-count lookup
package lsq_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_t;

  // Widest ROB tag the request struct can carry; the top slices its TAG_WIDTH out of it.
  localparam int TAG_MAX = 16;

  typedef struct packed {
    logic               wr;
    size_t              size;
    logic               unsgn;
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic [TAG_MAX-1:0] tag;
  } req_t;

  function automatic logic [2:0] nbytes_of(input size_t size);
    case (size)
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsq_mem_ctrl_load_extend.sv
// rtl/lsq_mem_ctrl_load_extend.sv - masks the assembled load bytes and sign/zero-extends by size
module load_extend
  import lsq_mem_pkg::*;
(
  input  logic [31:0] raw,
  input  size_t       size,
  input  logic        unsgn,
  output logic [31:0] data
);

  // Extend from the top bit of the highest byte actually loaded; words pass through.
  always_comb begin
    data = raw;
    case (size)
      SZ_B:    data = {{24{~unsgn & raw[7]}}, raw[7:0]};
      SZ_H:    data = {{16{~unsgn & raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsq_mem_ctrl.sv
// rtl/lsq_mem_ctrl.sv - byte-serial load/store sequencer; LSQ_MEM_CTRL_MISALIGN_TRAP_EN traps misaligned half/word
module lsq_mem_ctrl
  import lsq_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int TAG_WIDTH  = 6,
  parameter int MEM_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic                  resp_wr,
  output logic                  resp_err,
  output logic                  mem_cs,
  output logic                  mem_re,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_RD_LAT - 1);

  state_t                state, next_state;
  req_t                  req_q;
  logic [2:0]            cnt, nbytes, lat;
  logic                  err_q, fault, last_byte, lat_done;
  logic [31:0]           asm_q, load_data;
  logic [ADDR_WIDTH-1:0] cur_addr;

  assign cur_addr  = req_q.addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(cnt);
  assign last_byte = (cnt == nbytes - 3'd1);
  assign lat_done  = (lat == LAT_LAST);

  // Classify the incoming request: illegal size always faults, misalignment only when trapping.
  always_comb begin
    fault = (req_size == SZ_ILL);
`ifdef LSQ_MEM_CTRL_MISALIGN_TRAP_EN
    if (req_size == SZ_H && req_addr[0]) fault = 1'b1;
    if (req_size == SZ_W && req_addr[1:0] != 2'b00) fault = 1'b1;
`endif
  end

  load_extend u_load_extend (
    .raw   (asm_q),
    .size  (req_q.size),
    .unsgn (req_q.unsgn),
    .data  (load_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next state and memory/handshake strobes, all decoded from the current state.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_cs     = 1'b0;
    mem_re     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    case (state)
      IDLE: begin
        req_ready = rst;
        if (req_valid) next_state = fault ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_cs   = 1'b1;
        mem_addr = cur_addr;
        if (req_q.wr) begin
          mem_wr    = 1'b1;
          mem_wdata = req_q.wdata[{cnt[1:0], 3'b000} +: 8];
          if (last_byte) next_state = RESP;
        end else begin
          mem_re     = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        mem_cs   = 1'b1;
        mem_addr = cur_addr;
        if (lat_done) next_state = last_byte ? RESP : ACCESS;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Response fields only show in RESP so that everything reads 0 elsewhere, including reset.
  always_comb begin
    resp_err  = (state == RESP) && err_q;
    resp_wr   = (state == RESP) && req_q.wr;
    resp_tag  = (state == RESP) ? req_q.tag[TAG_WIDTH-1:0] : '0;
    resp_data = (state == RESP && !req_q.wr && !err_q) ? load_data : 32'h0;
  end

  // Request capture, byte counter, read-latency counter and load byte assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q  <= '0;
      cnt    <= 3'd0;
      nbytes <= 3'd1;
      lat    <= 3'd0;
      err_q  <= 1'b0;
      asm_q  <= 32'h0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_q.wr    <= req_wr;
          req_q.size  <= size_t'(req_size);
          req_q.unsgn <= req_unsigned;
          req_q.addr  <= req_addr;
          req_q.wdata <= req_wdata;
          req_q.tag   <= TAG_MAX'(req_tag);
          cnt         <= 3'd0;
          nbytes      <= nbytes_of(size_t'(req_size));
          lat         <= 3'd0;
          err_q       <= fault;
          asm_q       <= 32'h0;
        end
        ACCESS: begin
          lat <= 3'd0;
          if (req_q.wr) cnt <= cnt + 3'd1;
        end
        WAIT: begin
          if (lat_done) begin
            asm_q[{cnt[1:0], 3'b000} +: 8] <= mem_rdata;
            cnt <= cnt + 3'd1;
          end else begin
            lat <= lat + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
